// File: rtl/reg_sad_status_pkg.sv
// ---------------------------------------------------------------------------
// reg_sad_status_pkg
//   Shared definitions for the SAD status read block: register addresses on
//   the USB register bus and the bit layout of the status byte, kept in one
//   place so host-side tooling can mirror a single source.
// ---------------------------------------------------------------------------
package reg_sad_status_pkg;

  localparam logic [7:0] ADDR_SAD_STATUS     = 8'h3A;
  localparam logic [7:0] ADDR_SAD_TRIG_COUNT = 8'h3B;

  // Status byte layout, MSB first.
  typedef struct packed {
    logic [2:0] rsvd;
    logic       ovf;
    logic       xerr;
    logic       trig;
    logic       active;
    logic       armed;
  } sad_status_t;

endpackage

// File: rtl/reg_sad_status_if.sv
// ---------------------------------------------------------------------------
// reg_sad_status_if
//   USB register bus as seen by one reader block.
//   reg_address  : register address
//   reg_bytecnt  : byte index within a multi-byte register
//   reg_datai    : write data
//   reg_read     : read strobe, high for the whole read of one byte
//   reg_write    : write strobe
//   reg_datao    : registered read data, 0 when not selected
// ---------------------------------------------------------------------------
interface reg_sad_status_if #(
  parameter int pBYTECNT_SIZE = 7
);
  logic [7:0]               reg_address;
  logic [pBYTECNT_SIZE-1:0] reg_bytecnt;
  logic [7:0]               reg_datai;
  logic                     reg_read;
  logic                     reg_write;
  logic [7:0]               reg_datao;

  modport master (
    output reg_address, reg_bytecnt, reg_datai, reg_read, reg_write,
    input  reg_datao
  );

  modport slave (
    input  reg_address, reg_bytecnt, reg_datai, reg_read, reg_write,
    output reg_datao
  );
endinterface

// File: rtl/reg_sad_status_sad_sat_counter.sv
// ---------------------------------------------------------------------------
// sad_sat_counter
//   Saturating event counter. Stops at all-ones; a further increment while
//   saturated sets the overflow flag. Clear wins over a same-cycle increment
//   and resets both count and overflow.
//   clk_usb  : clock
//   reset_n  : async active-low reset
//   i_inc    : count one event
//   i_clr    : clear count and overflow
//   o_count  : current count
//   o_ovf    : overflow flag
// ---------------------------------------------------------------------------
module sad_sat_counter #(
  parameter int pWIDTH = 32
) (
  input  logic              clk_usb,
  input  logic              reset_n,
  input  logic              i_inc,
  input  logic              i_clr,
  output logic [pWIDTH-1:0] o_count,
  output logic              o_ovf
);

  logic [pWIDTH-1:0] r_count;
  logic              r_ovf;

  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (i_clr) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (i_inc) begin
      if (&r_count) r_ovf   <= 1'b1;
      else          r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_ovf   = r_ovf;

endmodule

// File: rtl/reg_sad_status.sv
// ---------------------------------------------------------------------------
// reg_sad_status
//   Read-side register block for the SAD trigger. Returns live and sticky SAD
//   status and a coherent multi-byte trigger count to the USB register bus.
//   reg_datao is 0 whenever not reading, so the top level can OR readers.
//   clk_usb        : USB register clock
//   reset_n        : async active-low reset
//   bus            : register bus (slave side)
//   sad_armed      : live armed level
//   sad_active     : live enable level
//   sad_trigger    : SAD match level, edge-detected here
//   xadc_error     : XADC alarm level
//   triggered_flag : sticky triggered flag
// ---------------------------------------------------------------------------
module reg_sad_status
  import reg_sad_status_pkg::*;
#(
  parameter int pBYTECNT_SIZE = 7,
  parameter int pCOUNT_WIDTH  = 32
) (
  input  logic             clk_usb,
  input  logic             reset_n,
  reg_sad_status_if.slave  bus,
  input  logic             sad_armed,
  input  logic             sad_active,
  input  logic             sad_trigger,
  input  logic             xadc_error,
  output logic             triggered_flag
);

  localparam int NBYTES = pCOUNT_WIDTH / 8;

  logic                     r_trig_d;
  logic                     r_read_d;
  logic [7:0]               r_rd_addr;
  logic [pBYTECNT_SIZE-1:0] r_rd_bcnt;
  logic                     r_trig_sticky;
  logic                     r_xerr_sticky;
  logic [pCOUNT_WIDTH-1:0]  r_snap;
  logic [7:0]               r_datao;

  logic                     w_trig_rise;
  logic                     w_read_rise;
  logic                     w_read_fall;
  logic                     w_stat_clr;
  logic                     w_cnt_clr;
  logic [pCOUNT_WIDTH-1:0]  w_count;
  logic                     w_ovf;
  logic [pCOUNT_WIDTH-1:0]  w_cnt_src;
  sad_status_t              w_stat;
  logic [7:0]               w_mux;
  logic                     w_unused_datai;

  assign w_trig_rise = sad_trigger & ~r_trig_d;
  assign w_read_rise = bus.reg_read & ~r_read_d;
  assign w_read_fall = r_read_d & ~bus.reg_read;

  // Clear-on-read acts when the read ends, using the address held during it.
  assign w_stat_clr = w_read_fall && (r_rd_addr == ADDR_SAD_STATUS) && (r_rd_bcnt == '0);
  assign w_cnt_clr  = bus.reg_write && (bus.reg_address == ADDR_SAD_TRIG_COUNT) && bus.reg_datai[0];

  assign w_unused_datai = ^bus.reg_datai[7:1];

  sad_sat_counter #(.pWIDTH(pCOUNT_WIDTH)) u_counter (
    .clk_usb (clk_usb),
    .reset_n (reset_n),
    .i_inc   (w_trig_rise),
    .i_clr   (w_cnt_clr),
    .o_count (w_count),
    .o_ovf   (w_ovf)
  );

  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      r_trig_d      <= 1'b0;
      r_read_d      <= 1'b0;
      r_rd_addr     <= '0;
      r_rd_bcnt     <= '0;
      r_trig_sticky <= 1'b0;
      r_xerr_sticky <= 1'b0;
      r_snap        <= '0;
      r_datao       <= '0;
    end else begin
      r_trig_d <= sad_trigger;
      r_read_d <= bus.reg_read;
      if (bus.reg_read) begin
        r_rd_addr <= bus.reg_address;
        r_rd_bcnt <= bus.reg_bytecnt;
      end
      // A set event in the clearing cycle keeps the bit.
      r_trig_sticky <= w_trig_rise | (r_trig_sticky & ~w_stat_clr);
      r_xerr_sticky <= xadc_error  | (r_xerr_sticky & ~w_stat_clr);
      // Snapshot takes the pre-increment count so all bytes agree.
      if (w_read_rise && (bus.reg_bytecnt == '0)) r_snap <= w_count;
      r_datao <= bus.reg_read ? w_mux : 8'h00;
    end
  end

  assign w_stat = '{rsvd: 3'b000, ovf: w_ovf, xerr: r_xerr_sticky, trig: r_trig_sticky,
                    active: sad_active, armed: sad_armed};

  // On the cycle the snapshot is taken, byte 0 comes from the same live count.
  assign w_cnt_src = (w_read_rise && (bus.reg_bytecnt == '0)) ? w_count : r_snap;

  always_comb begin
    w_mux = 8'h00;
    if (bus.reg_address == ADDR_SAD_STATUS) begin
      if (bus.reg_bytecnt == '0) w_mux = w_stat;
    end else if (bus.reg_address == ADDR_SAD_TRIG_COUNT) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (32'(bus.reg_bytecnt) == i) w_mux = w_cnt_src[8*i +: 8];
      end
    end
  end

  assign bus.reg_datao   = r_datao;
  assign triggered_flag  = r_trig_sticky;

endmodule

// File: tb/tb_reg_sad_status.sv
module tb_reg_sad_status;
  import reg_sad_status_pkg::*;

  logic clk_usb = 1'b0;
  logic reset_n = 1'b0;
  logic sad_armed = 1'b0;
  logic sad_active = 1'b0;
  logic sad_trigger = 1'b0;
  logic xadc_error = 1'b0;
  logic trig_flag32, trig_flag8;
  int   total = 0;
  int   bad = 0;

  reg_sad_status_if #(.pBYTECNT_SIZE(7)) bus ();
  reg_sad_status_if #(.pBYTECNT_SIZE(7)) bus8 ();

  // The 8-bit-counter instance sees identical bus stimulus.
  assign bus8.reg_address = bus.reg_address;
  assign bus8.reg_bytecnt = bus.reg_bytecnt;
  assign bus8.reg_datai   = bus.reg_datai;
  assign bus8.reg_read    = bus.reg_read;
  assign bus8.reg_write   = bus.reg_write;

  reg_sad_status #(.pBYTECNT_SIZE(7), .pCOUNT_WIDTH(32)) u_dut32 (
    .clk_usb(clk_usb), .reset_n(reset_n), .bus(bus),
    .sad_armed(sad_armed), .sad_active(sad_active), .sad_trigger(sad_trigger),
    .xadc_error(xadc_error), .triggered_flag(trig_flag32));

  reg_sad_status #(.pBYTECNT_SIZE(7), .pCOUNT_WIDTH(8)) u_dut8 (
    .clk_usb(clk_usb), .reset_n(reset_n), .bus(bus8),
    .sad_armed(sad_armed), .sad_active(sad_active), .sad_trigger(sad_trigger),
    .xadc_error(xadc_error), .triggered_flag(trig_flag8));

  always #5 clk_usb = ~clk_usb;

  task automatic tick;
    @(posedge clk_usb);
    #1;
  endtask

  task automatic read_byte(input logic [7:0] a, input logic [6:0] b,
                           output logic [7:0] d32, output logic [7:0] d8);
    bus.reg_address = a;
    bus.reg_bytecnt = b;
    bus.reg_read    = 1'b1;
    tick;
    d32 = bus.reg_datao;
    d8  = bus8.reg_datao;
    bus.reg_read = 1'b0;
    tick;
  endtask

  task automatic write_byte(input logic [7:0] a, input logic [7:0] d);
    bus.reg_address = a;
    bus.reg_bytecnt = '0;
    bus.reg_datai   = d;
    bus.reg_write   = 1'b1;
    tick;
    bus.reg_write = 1'b0;
    tick;
  endtask

  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      sad_trigger = 1'b1;
      tick;
      sad_trigger = 1'b0;
      tick;
    end
  endtask

  task automatic test_reset;
    logic [7:0] d32, d8;
    repeat (3) tick;
    total++;
    if (bus.reg_datao !== 8'h00 || trig_flag32 !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: datao=%h flag=%b, want 00 0", bus.reg_datao, trig_flag32);
    end
    reset_n = 1'b1;
    tick;
    sad_armed  = 1'b1;
    xadc_error = 1'b1;
    tick;
    pulse(1);
    bus.reg_address = ADDR_SAD_STATUS;
    bus.reg_bytecnt = '0;
    bus.reg_read    = 1'b1;
    tick;
    total++;
    if (bus.reg_datao !== 8'h0D) begin
      bad++;
      $display("FAIL pre_reset_status: got %h want 0D", bus.reg_datao);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (bus.reg_datao !== 8'h00) begin
      bad++;
      $display("FAIL reset_midread_async: got %h want 00", bus.reg_datao);
    end
    tick;
    total++;
    if (bus.reg_datao !== 8'h00 || trig_flag32 !== 1'b0) begin
      bad++;
      $display("FAIL reset_midread_held: datao=%h flag=%b want 00 0", bus.reg_datao, trig_flag32);
    end
    xadc_error   = 1'b0;
    bus.reg_read = 1'b0;
    reset_n      = 1'b1;
    tick;
    read_byte(ADDR_SAD_STATUS, 7'd0, d32, d8);
    total++;
    if (d32 !== 8'h01 || d8 !== 8'h01) begin
      bad++;
      $display("FAIL reset_sticky_clear: got %h/%h want 01", d32, d8);
    end
  endtask

  task automatic test_sticky_trig;
    logic [7:0] d32, d8;
    sad_armed  = 1'b1;
    sad_active = 1'b1;
    pulse(3);
    total++;
    if (trig_flag32 !== 1'b1) begin
      bad++;
      $display("FAIL triggered_flag_set: got %b want 1", trig_flag32);
    end
    read_byte(ADDR_SAD_STATUS, 7'd0, d32, d8);
    total++;
    if (d32 !== 8'h07) begin
      bad++;
      $display("FAIL status_after_trig: got %h want 07", d32);
    end
    read_byte(ADDR_SAD_STATUS, 7'd0, d32, d8);
    total++;
    if (d32 !== 8'h03 || trig_flag32 !== 1'b0) begin
      bad++;
      $display("FAIL status_cleared: got %h flag=%b want 03 0", d32, trig_flag32);
    end
  endtask

  task automatic test_xerr;
    logic [7:0] d32, d8;
    xadc_error = 1'b1;
    tick;
    xadc_error = 1'b0;
    tick;
    read_byte(ADDR_SAD_STATUS, 7'd0, d32, d8);
    total++;
    if (d32 !== 8'h0B) begin
      bad++;
      $display("FAIL xerr_sticky: got %h want 0B", d32);
    end
    read_byte(ADDR_SAD_STATUS, 7'd0, d32, d8);
    total++;
    if (d32 !== 8'h03) begin
      bad++;
      $display("FAIL xerr_cleared: got %h want 03", d32);
    end
  endtask

  task automatic test_set_wins_clear;
    logic [7:0] d32, d8;
    bus.reg_address = ADDR_SAD_STATUS;
    bus.reg_bytecnt = '0;
    bus.reg_read    = 1'b1;
    tick;
    total++;
    if (bus.reg_datao !== 8'h03) begin
      bad++;
      $display("FAIL set_clear_first_read: got %h want 03", bus.reg_datao);
    end
    bus.reg_read = 1'b0;
    sad_trigger  = 1'b1;
    tick;
    sad_trigger = 1'b0;
    tick;
    read_byte(ADDR_SAD_STATUS, 7'd0, d32, d8);
    total++;
    if (d32 !== 8'h07) begin
      bad++;
      $display("FAIL set_wins_clear: got %h want 07", d32);
    end
    read_byte(ADDR_SAD_STATUS, 7'd0, d32, d8);
    total++;
    if (d32 !== 8'h03) begin
      bad++;
      $display("FAIL set_wins_then_clear: got %h want 03", d32);
    end
  endtask

  task automatic test_count_coherent;
    logic [7:0] d32, d8;
    logic [7:0] exp1 [4];
    logic [7:0] exp2 [4];
    exp1 = '{8'hFF, 8'h00, 8'h00, 8'h00};
    exp2 = '{8'h00, 8'h01, 8'h00, 8'h00};
    write_byte(ADDR_SAD_TRIG_COUNT, 8'h01);
    pulse(255);
    read_byte(ADDR_SAD_TRIG_COUNT, 7'd0, d32, d8);
    total++;
    if (d32 !== exp1[0]) begin
      bad++;
      $display("FAIL count_snap_b0: got %h want %h", d32, exp1[0]);
    end
    pulse(1);
    for (int b = 1; b < 4; b++) begin
      read_byte(ADDR_SAD_TRIG_COUNT, 7'(b), d32, d8);
      total++;
      if (d32 !== exp1[b]) begin
        bad++;
        $display("FAIL count_snap_b%0d: got %h want %h", b, d32, exp1[b]);
      end
    end
    for (int b = 0; b < 4; b++) begin
      read_byte(ADDR_SAD_TRIG_COUNT, 7'(b), d32, d8);
      total++;
      if (d32 !== exp2[b]) begin
        bad++;
        $display("FAIL count_next_b%0d: got %h want %h", b, d32, exp2[b]);
      end
    end
  endtask

  task automatic test_saturate;
    logic [7:0] d32, d8;
    write_byte(ADDR_SAD_TRIG_COUNT, 8'h01);
    pulse(255);
    read_byte(ADDR_SAD_STATUS, 7'd0, d32, d8);
    total++;
    if (d8[4] !== 1'b0) begin
      bad++;
      $display("FAIL sat_no_ovf_yet: ovf=%b want 0", d8[4]);
    end
    pulse(1);
    read_byte(ADDR_SAD_TRIG_COUNT, 7'd0, d32, d8);
    total++;
    if (d8 !== 8'hFF || d32 !== 8'h00) begin
      bad++;
      $display("FAIL sat_count: got8=%h got32=%h want FF 00", d8, d32);
    end
    read_byte(ADDR_SAD_STATUS, 7'd0, d32, d8);
    total++;
    if (d8[4] !== 1'b1 || d32[4] !== 1'b0) begin
      bad++;
      $display("FAIL sat_ovf: ovf8=%b ovf32=%b want 1 0", d8[4], d32[4]);
    end
    write_byte(ADDR_SAD_TRIG_COUNT, 8'h00);
    read_byte(ADDR_SAD_TRIG_COUNT, 7'd0, d32, d8);
    total++;
    if (d8 !== 8'hFF) begin
      bad++;
      $display("FAIL clear_needs_bit0: got %h want FF", d8);
    end
    write_byte(ADDR_SAD_TRIG_COUNT, 8'h01);
    read_byte(ADDR_SAD_TRIG_COUNT, 7'd0, d32, d8);
    total++;
    if (d8 !== 8'h00 || d32 !== 8'h00) begin
      bad++;
      $display("FAIL clear_count: got8=%h got32=%h want 00", d8, d32);
    end
    read_byte(ADDR_SAD_STATUS, 7'd0, d32, d8);
    total++;
    if (d8[4] !== 1'b0) begin
      bad++;
      $display("FAIL clear_ovf: ovf=%b want 0", d8[4]);
    end
  endtask

  task automatic test_unused;
    logic [7:0] d32, d8;
    read_byte(8'h10, 7'd0, d32, d8);
    total++;
    if (d32 !== 8'h00) begin
      bad++;
      $display("FAIL unused_addr: got %h want 00", d32);
    end
    read_byte(ADDR_SAD_TRIG_COUNT, 7'd4, d32, d8);
    total++;
    if (d32 !== 8'h00) begin
      bad++;
      $display("FAIL count_bcnt4: got %h want 00", d32);
    end
    read_byte(ADDR_SAD_STATUS, 7'd1, d32, d8);
    total++;
    if (d32 !== 8'h00) begin
      bad++;
      $display("FAIL status_bcnt1: got %h want 00", d32);
    end
    bus.reg_address = ADDR_SAD_STATUS;
    bus.reg_bytecnt = '0;
    for (int i = 0; i < 3; i++) begin
      tick;
      total++;
      if (bus.reg_datao !== 8'h00) begin
        bad++;
        $display("FAIL idle_datao: got %h want 00", bus.reg_datao);
      end
    end
  endtask

  initial begin
    bus.reg_address = '0;
    bus.reg_bytecnt = '0;
    bus.reg_datai   = '0;
    bus.reg_read    = 1'b0;
    bus.reg_write   = 1'b0;
    test_reset;
    test_sticky_trig;
    test_xerr;
    test_set_wins_clear;
    test_count_coherent;
    test_saturate;
    test_unused;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
